// File: rtl/redmule_w_loader_pkg.sv
// Shared types for the W loader: element formats, W buffer control word and loader FSM states.
package redmule_w_loader_pkg;

  typedef enum logic [1:0] {
    FP8,
    FP16,
    FP32
  } fp_format_e;

  function automatic int unsigned fp_width(input fp_format_e fmt);
    case (fmt)
      FP8:     return 8;
      FP32:    return 32;
      default: return 16;
    endcase
  endfunction

  localparam int unsigned ARRAY_HEIGHT = 4;
  localparam int unsigned W_DW         = 288;
  localparam int unsigned W_ELEMS      = W_DW / fp_width(FP16);
  localparam int unsigned W_ROWS_W     = $clog2(ARRAY_HEIGHT) + 1;
  localparam int unsigned W_COLS_W     = $clog2(W_ELEMS) + 1;

  typedef struct packed {
    logic                load;
    logic                shift;
    logic [W_ROWS_W-1:0] rows_lftovr;
    logic [W_COLS_W-1:0] cols_lftovr;
  } w_buffer_ctrl_t;

  typedef enum logic [1:0] {
    WLdrIdle,
    WLdrRun,
    WLdrDrain
  } w_ldr_state_e;

endpackage

// File: rtl/redmule_w_loader_fifo.sv
// Registered-output (non fall-through) FIFO: a word pushed at edge t is visible in cycle t+1.
module redmule_w_loader_fifo #(
  parameter int unsigned DataWidth = 288,
  parameter int unsigned Depth     = 4,
  localparam int unsigned AW       = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW     = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam logic [AW-1:0]   LastPtr = AW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      cnt_q;
  logic                 do_push, do_pop;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/redmule_w_loader.sv
// W row-buffer loader: buffers streamed weight words and sequences per-step load/shift control
// across tiles, with row/column leftovers on the final tile and a shift-only drain at the end.
module redmule_w_loader
  import redmule_w_loader_pkg::*;
#(
  parameter int unsigned DW        = 288,
  parameter fp_format_e  FpFormat  = FP16,
  parameter int unsigned Height    = ARRAY_HEIGHT,
  parameter int unsigned FifoDepth = 4,
  localparam int unsigned BITW     = fp_width(FpFormat),
  localparam int unsigned D        = DW / BITW,
  localparam int unsigned RW       = $clog2(Height) + 1,
  localparam int unsigned CW       = $clog2(D) + 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clear_i,
  input  logic           start_i,
  input  logic [15:0]    n_tiles_i,
  input  logic [RW-1:0]  rows_lftovr_i,
  input  logic [CW-1:0]  cols_lftovr_i,
  input  logic [DW-1:0]  w_data_i,
  input  logic           w_valid_i,
  output logic           w_ready_o,
  input  logic           advance_i,
  output logic [DW-1:0]  w_data_o,
  output w_buffer_ctrl_t ctrl_o,
  output logic           stall_o,
  output logic           busy_o,
  output logic           done_o
);

  if (D < Height) begin : gen_cfg_err
    $error("redmule_w_loader: DW/BITW must be at least Height");
  end

  localparam logic [CW-1:0] LastStep   = CW'(D - 1);
  localparam logic [CW-1:0] HeightStep = CW'(Height);

  w_ldr_state_e  state_q;
  logic [CW-1:0] step_q;
  logic [15:0]   tile_q, n_tiles_q;
  logic [RW-1:0] rows_q;
  logic [CW-1:0] cols_q;
  logic          done_q;

  logic          fifo_full, fifo_empty, fifo_pop;
  logic [DW-1:0] fifo_head;

  logic          final_tile, in_load, row_active, data_missing, do_step;
  logic [RW-1:0] valid_rows;

  redmule_w_loader_fifo #(
    .DataWidth (DW),
    .Depth     (FifoDepth)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .push_i  (w_valid_i),
    .data_i  (w_data_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    final_tile = (state_q != WLdrIdle) && (tile_q == n_tiles_q);
    valid_rows = RW'(Height);
    if (final_tile && (rows_q != '0)) valid_rows = rows_q;
    in_load      = (state_q == WLdrRun) && (step_q < HeightStep);
    row_active   = in_load && (step_q < CW'(valid_rows));
    // Rows past the leftover still issue a load (with zero data) to keep the row pointer aligned.
    data_missing = row_active && fifo_empty;
    do_step      = advance_i && !data_missing && (state_q != WLdrIdle);
    fifo_pop     = do_step && row_active;
  end

  always_comb begin
    ctrl_o             = '0;
    ctrl_o.shift       = do_step;
    ctrl_o.load        = do_step && in_load;
    ctrl_o.rows_lftovr = final_tile ? W_ROWS_W'(rows_q) : '0;
    ctrl_o.cols_lftovr = final_tile ? W_COLS_W'(cols_q) : '0;
  end

  assign w_data_o  = fifo_pop ? fifo_head : '0;
  assign stall_o   = advance_i && data_missing;
  assign w_ready_o = !fifo_full;
  assign busy_o    = (state_q != WLdrIdle);
  assign done_o    = done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= WLdrIdle;
      step_q    <= '0;
      tile_q    <= '0;
      n_tiles_q <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
      done_q    <= 1'b0;
    end else if (clear_i) begin
      state_q   <= WLdrIdle;
      step_q    <= '0;
      tile_q    <= '0;
      n_tiles_q <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        WLdrIdle: begin
          if (start_i) begin
            if (n_tiles_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q   <= WLdrRun;
              n_tiles_q <= n_tiles_i;
              rows_q    <= rows_lftovr_i;
              cols_q    <= cols_lftovr_i;
              tile_q    <= 16'd1;
              step_q    <= '0;
            end
          end
        end
        WLdrRun: begin
          if (do_step) begin
            if (step_q == LastStep) begin
              step_q <= '0;
              // Tile stays at the final value through drain so leftovers remain visible.
              if (tile_q == n_tiles_q) state_q <= WLdrDrain;
              else                     tile_q  <= tile_q + 16'd1;
            end else begin
              step_q <= step_q + CW'(1);
            end
          end
        end
        WLdrDrain: begin
          if (do_step) begin
            if (step_q == LastStep) begin
              state_q <= WLdrIdle;
              done_q  <= 1'b1;
              step_q  <= '0;
              tile_q  <= '0;
            end else begin
              step_q <= step_q + CW'(1);
            end
          end
        end
        default: state_q <= WLdrIdle;
      endcase
    end
  end

endmodule
